irq_encoder_8_3: RTL and testbench
==================================

# irq_encoder_8_3

Sequential 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the encoding counterpart of `decoder_3_8`: it collects eight rising-edge request lines into a pending register, selects one winner, and presents it as a 3-bit index plus a one-hot copy. The selected index is held stable until the consumer acknowledges it. It sits between the interrupt/event sources and any block that consumes a binary select, such as a `sel_8_1` select input or a `decoder_3_8` address.

## Interface
- `ROUND_ROBIN`, default 0. 0 = fixed priority, lowest index wins. 1 = rotating priority; the search starts at last granted index + 1, mod 8.
- `clk`, input, 1. Single clock; all state updates on the rising edge.
- `n_rst`, input, 1. Reset, asynchronous, active-low.
- `n_EN`, input, 1. Active-low grant enable. When high, no new grant is issued.
- `req`, input, 8. Request lines; a rising edge on `req[i]` raises a request.
- `mask`, input, 8. `mask[i]=1` excludes bit i from selection only; the request still latches.
- `ack`, input, 1. Consumer accepts the presented index.
- `valid`, output, 1. `code`/`onehot` hold a granted request.
- `code`, output, 3. Granted index.
- `onehot`, output, 8. `1 << code` while `valid`, else 0.
- `pending`, output, 8. Latched, not-yet-acknowledged requests.
- `ovf`, output, 1. Sticky: a request edge was lost.

## Operation
- Edge detect:
  - `req_q` registers `req` every cycle.
  - `rise = req & ~req_q`.
- Pending register, per bit:
  - set by `rise[i]`;
  - cleared when `ack && valid && code==i`;
  - set and clear in the same cycle: set wins, so the bit stays 1.
- Overflow:
  - `ovf` sets when `rise[i] && pending[i]` and bit i is not being cleared that cycle.
  - `ovf` is cleared only by reset.
- Candidates: `cand = pending & ~mask`.
- FSM states:
  - IDLE: if `n_EN==0 && cand!=0`, register the winner into `code`/`onehot`, set `valid`, go to PRESENT. Otherwise stay.
  - PRESENT: `code`/`onehot`/`valid` are frozen; changes to `pending`, `mask` and `n_EN` have no effect. On `ack`, clear `valid` and `onehot`, clear `pending[code]`, record `last = code`, and return to IDLE.
- Selection is evaluated only in IDLE.
  - Fixed priority: lowest set index of `cand`.
  - Round robin: first set bit of `cand` scanning `last+1, last+2, …` with wrap 7→0.
- `ack` while `valid==0` is ignored.
- `n_EN` rising while in PRESENT does not abort the grant; the grant completes on `ack`.
- `code` keeps its last value while `valid==0`; consumers must qualify it with `valid`.
- Asynchronous reset, immediate and valid at any point including mid-handshake:
  - `valid=0`, `code=0`, `onehot=0`, `pending=0`, `ovf=0`, `req_q=0`;
  - state = IDLE;
  - `last=7`, so the first round-robin search starts at index 0.
  - A request line already high when reset releases produces no edge; the request is lost with no `ovf`.

## Timing
- Request to grant:
  - `req[i]` rises before edge k → `pending[i]=1` after edge k.
  - If in IDLE and enabled → `valid=1`, `code=i` after edge k+1.
  - Minimum latency is 2 cycles.
- Ack to next grant:
  - `ack` sampled high at edge m → `valid=0` and the pending bit cleared after edge m.
  - The next grant appears after edge m+1 at the earliest.
  - `valid` is therefore low for at least one cycle between grants; a sustained back-to-back rate is one grant per 2 cycles.
- `ack` may be held high continuously; each grant then lasts exactly one cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset state:
  - assert `n_rst=0` mid-PRESENT with `pending=8'hA5`;
  - → all outputs are 0 immediately;
  - after release, `valid` stays 0 until a new `req` edge.
- Fixed priority:
  - `ROUND_ROBIN=0`; pulse `req=8'h90` at edge k; hold `ack=1`;
  - → `valid` after k+1 with `code=4`, `onehot=8'h10`;
  - then `code=7` two cycles later; `pending=0` at the end.
- Round robin:
  - `ROUND_ROBIN=1`; pulse `req=8'h05`; ack each grant;
  - then pulse `req=8'h05` again after index 2 has been served;
  - → grant order 0, 2, then 0, 2 (the search restarts at 3 and wraps to 0).
- Enable and mask:
  - `n_EN=1`, pulse `req[3]` → no `valid`, `pending=8'h08`;
  - set `mask=8'h08` and `n_EN=0` → still no grant;
  - clear the mask → `code=3` one cycle later.
- Hold and ack-ignore:
  - during PRESENT with `code=1`, pulse `req[0]` and change `mask`;
  - → `code` stays 1 until `ack`;
  - `ack` pulsed with `valid=0` → no change to `pending`.
- Collisions:
  - `req[2]` edge in the same cycle as an `ack` for `code=2` → `pending[2]` remains 1 and `ovf` stays 0;
  - `req[5]` edge while `pending[5]=1` → `ovf=1` and it stays set until reset.

Source files
------------

// File: rtl/irq_encoder_8_3.sv
// Sequential 8-to-3 priority encoder: latches request edges into a pending set,
// grants one winner (fixed or rotating priority) and holds it until acknowledged.
//
// state   | meaning
// IDLE    | no grant presented; selection runs each cycle when enabled
// PRESENT | code/onehot/valid frozen until ack
module irq_encoder_8_3 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       n_EN,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] code,
  output logic [7:0] onehot,
  output logic [7:0] pending,
  output logic       ovf
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state;
  logic [7:0] req_q;
  logic [2:0] last;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;

  assign rise = req & ~req_q;
  // onehot mirrors code while valid, so it doubles as the clear mask
  assign clr  = (ack && valid) ? onehot : 8'h00;
  assign cand = pending & ~mask;

  always_comb begin
    win   = 3'd0;
    idx   = 3'd0;
    found = 1'b0;
    if (ROUND_ROBIN) begin
      for (int k = 1; k <= 8; k++) begin
        idx = last + 3'(k);
        if (!found && cand[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) win = 3'(i);
      end
      found = |cand;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_q   <= 8'h00;
      pending <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr) | rise;
      if (|(rise & pending & ~clr)) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      valid  <= 1'b0;
      code   <= 3'd0;
      onehot <= 8'h00;
      last   <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (!n_EN && found) begin
            code   <= win;
            onehot <= 8'h01 << win;
            valid  <= 1'b1;
            state  <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid  <= 1'b0;
            onehot <= 8'h00;
            last   <= code;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Self-checking bench: fixed-priority and round-robin instances driven in
// parallel and compared every cycle against a behavioural model.
module tb_irq_encoder_8_3;
  logic       clk = 1'b0;
  logic       n_rst, n_EN, ack;
  logic [7:0] req, mask;
  logic       valid0, valid1, ovf0, ovf1;
  logic [2:0] code0, code1;
  logic [7:0] onehot0, onehot1, pending0, pending1;

  int tests = 0;
  int fails = 0;

  bit         m_busy[2];
  int         m_code[2];
  int         m_last[2];
  bit [7:0]   m_pend[2];
  bit         m_ovf[2];
  bit [7:0]   m_reqp;

  always #5 clk = ~clk;

  irq_encoder_8_3 #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .n_EN(n_EN), .req(req), .mask(mask), .ack(ack),
    .valid(valid0), .code(code0), .onehot(onehot0), .pending(pending0), .ovf(ovf0));

  irq_encoder_8_3 #(.ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .n_EN(n_EN), .req(req), .mask(mask), .ack(ack),
    .valid(valid1), .code(code1), .onehot(onehot1), .pending(pending1), .ovf(ovf1));

  // Index of the winner among candidates, or -1 when there is none.
  function automatic int pick(int rr, bit [7:0] cand, int last);
    for (int off = 1; off <= 8; off++) begin
      int n;
      n = rr ? (last + off) % 8 : off - 1;
      if (cand[n]) return n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_code[d] = 0; m_last[d] = 7; m_pend[d] = 0; m_ovf[d] = 0;
    end
    m_reqp = 0;
  endtask

  task automatic model_edge();
    bit [7:0] rise;
    rise = req & ~m_reqp;
    for (int d = 0; d < 2; d++) begin
      bit [7:0] served;
      int w;
      served = 0;
      if (m_busy[d] && ack) served[m_code[d]] = 1'b1;
      if ((rise & m_pend[d] & ~served) != 0) m_ovf[d] = 1;
      w = pick(d, m_pend[d] & ~mask, m_last[d]);
      m_pend[d] = (m_pend[d] & ~served) | rise;
      if (m_busy[d]) begin
        if (ack) begin
          m_busy[d] = 0;
          m_last[d] = m_code[d];
        end
      end else if (!n_EN && w >= 0) begin
        m_busy[d] = 1;
        m_code[d] = w;
      end
    end
    m_reqp = req;
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    logic [7:0] oh0, oh1;
    oh0 = m_busy[0] ? (8'h01 << m_code[0]) : 8'h00;
    oh1 = m_busy[1] ? (8'h01 << m_code[1]) : 8'h00;
    check("fp_valid",   {7'd0, valid0}, {7'd0, m_busy[0]});
    check("fp_onehot",  onehot0,  oh0);
    check("fp_pending", pending0, m_pend[0]);
    check("fp_ovf",     {7'd0, ovf0}, {7'd0, m_ovf[0]});
    check("rr_valid",   {7'd0, valid1}, {7'd0, m_busy[1]});
    check("rr_onehot",  onehot1,  oh1);
    check("rr_pending", pending1, m_pend[1]);
    check("rr_ovf",     {7'd0, ovf1}, {7'd0, m_ovf[1]});
    if (m_busy[0]) check("fp_code", {5'd0, code0}, 8'(m_code[0]));
    if (m_busy[1]) check("rr_code", {5'd0, code1}, 8'(m_code[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic check_zero(string tag);
    check({tag, "_v"},  {6'd0, valid0, valid1}, 8'h00);
    check({tag, "_c"},  {2'd0, code0, code1}, 8'h00);
    check({tag, "_oh"}, onehot0 | onehot1, 8'h00);
    check({tag, "_p"},  pending0 | pending1, 8'h00);
    check({tag, "_o"},  {6'd0, ovf0, ovf1}, 8'h00);
  endtask

  initial begin
    n_rst = 1'b0; n_EN = 1'b0; ack = 1'b0; req = 8'h00; mask = 8'h00;
    model_reset();
    #3;
    check_zero("por");
    #9 n_rst = 1'b1;
    step(); step();

    // fixed priority with ack held: 4 then 7
    req = 8'h90; step();
    req = 8'h00; ack = 1'b1; step();
    check("fp_first_code", {5'd0, code0}, 8'd4);
    check("fp_first_oh", onehot0, 8'h10);
    step(); step();
    check("fp_second_code", {5'd0, code0}, 8'd7);
    step();
    check("fp_end_pending", pending0, 8'h00);
    ack = 1'b0; step();

    // round robin: 0, 2, then 0, 2 again after wrap
    req = 8'h05; step();
    req = 8'h00; ack = 1'b1; step();
    check("rr_g1", {4'd0, valid1, code1}, 8'h08);
    step(); step();
    check("rr_g2", {4'd0, valid1, code1}, 8'h0A);
    step();
    req = 8'h05; step();
    req = 8'h00; step();
    check("rr_g3", {4'd0, valid1, code1}, 8'h08);
    step(); step();
    check("rr_g4", {4'd0, valid1, code1}, 8'h0A);
    step();
    ack = 1'b0; step();

    // enable and mask gating
    n_EN = 1'b1; req = 8'h08; step();
    req = 8'h00; step(); step();
    check("en_novalid", {7'd0, valid0}, 8'h00);
    check("en_pending", pending0, 8'h08);
    mask = 8'h08; n_EN = 1'b0; step(); step();
    check("mask_novalid", {7'd0, valid0}, 8'h00);
    mask = 8'h00; step();
    check("unmask_grant", {4'd0, valid0, code0}, 8'h0B);
    ack = 1'b1; step();
    ack = 1'b0; step();

    // hold during PRESENT, then ack while idle is ignored
    req = 8'h02; step();
    req = 8'h00; step();
    req = 8'h01; step();
    req = 8'h00; mask = 8'hFF; step();
    n_EN = 1'b1; step();
    check("hold_fp", {4'd0, valid0, code0}, 8'h09);
    check("hold_rr", {4'd0, valid1, code1}, 8'h09);
    ack = 1'b1; step();
    step(); step();
    check("ack_idle_pending", pending0, 8'h01);
    ack = 1'b0; n_EN = 1'b0; mask = 8'h00; step();
    ack = 1'b1; step();
    ack = 1'b0; step();

    // collisions: set beats clear, then a genuine lost edge
    req = 8'h04; step();
    req = 8'h00; step();
    ack = 1'b1; req = 8'h04; step();
    check("coll_pending", pending0 & 8'h04, 8'h04);
    check("coll_ovf", {6'd0, ovf0, ovf1}, 8'h00);
    ack = 1'b0; req = 8'h00; step();
    ack = 1'b1; step();
    ack = 1'b0; n_EN = 1'b1; req = 8'h20; step();
    req = 8'h00; step();
    req = 8'h20; step();
    check("ovf_set", {6'd0, ovf0, ovf1}, 8'h03);
    req = 8'h00; n_EN = 1'b0; ack = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("ovf_sticky", {6'd0, ovf0, ovf1}, 8'h03);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req  = 8'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      n_EN = ($urandom_range(0, 7) == 0);
      ack  = ($urandom_range(0, 2) != 0);
      step();
    end

    // reset mid-handshake with pending A5
    req = 8'h00; mask = 8'h00; ack = 1'b0; n_EN = 1'b1;
    n_rst = 1'b0; model_reset(); #4 n_rst = 1'b1;
    step();
    req = 8'hA5; step();
    req = 8'h00; step();
    n_EN = 1'b0; step();
    check("pre_rst_state", {7'd0, valid0}, 8'h01);
    check("pre_rst_pending", pending0, 8'hA5);
    #2 n_rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #3 n_rst = 1'b1;
    step(); step(); step();
    check("post_rst_idle", {6'd0, valid0, valid1}, 8'h00);
    req = 8'h80; step();
    req = 8'h00; step();
    check("post_rst_grant", {4'd0, valid1, code1}, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
